// File: rtl/alu_exec_stage_if.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_if
//   Bundles both handshake sides of the ALU execute stage.
//
//   Handshake rule (applies to the in_* side and the out_* side alike):
//     A transfer happens on a rising clock edge where valid and ready are both 1.
//     The producer holds valid and its payload steady until that transfer.
//     Ready may change freely and never depends on a future valid.
//
//   Signals
//     in_valid / in_ready      upstream operation handshake
//     alu_ctl, src_a, src_b    operation code and operands (payload of in_*)
//     out_valid / out_ready    downstream result handshake
//     alu_result, zero, ovf,
//     illegal_op               registered result and flags (payload of out_*)
//
//   Modports
//     slave  : the execute stage itself
//     master : the surrounding pipeline (upstream producer + downstream consumer)
// ---------------------------------------------------------------------------
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             ovf;
    logic             illegal_op;

    modport slave (
        input  in_valid, alu_ctl, src_a, src_b, out_ready,
        output in_ready, out_valid, alu_result, zero, ovf, illegal_op
    );

    modport master (
        output in_valid, alu_ctl, src_a, src_b, out_ready,
        input  in_ready, out_valid, alu_result, zero, ovf, illegal_op
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Registered execute stage: takes a 4-bit ALU control code plus two operands
//   and produces a registered result with zero / signed-overflow / illegal-op
//   flags. Valid/ready on both sides so stalls propagate through the pipeline.
//
//   Parameters
//     WIDTH        operand/result width in bits (>= 2)
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          alu_exec_stage_if.slave (handshakes, operands, result, flags)
//     dbg_state    occupancy of the stage: 0 empty, 1 one result, 2 result + skid
//
//   Opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR; anything else is
//   illegal and yields result 0, zero=1, illegal_op=1 (still a normal transfer).
//
//   Build option
//     ALU_SKID_EN  defined: one-entry skid buffer, in_ready comes from a flop.
//                  undefined: single output register, in_ready = ~out_valid | out_ready.
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_stage_if.slave      bus,
    output logic [1:0]           dbg_state
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
    } res_t;

    // ---------------- combinational ALU ----------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    res_t             calc;

    always_comb begin
        op_a = bus.src_a;
        op_b = bus.src_b;
        sum  = op_a + op_b;
        diff = op_a - op_b;
        calc = '0;
        case (bus.alu_ctl)
            OP_AND: calc.result = op_a & op_b;
            OP_OR:  calc.result = op_a | op_b;
            OP_ADD: begin
                calc.result = sum;
                // Same-sign operands whose sum flips sign.
                calc.ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                calc.result = diff;
                // Opposite-sign operands whose difference leaves a's sign.
                calc.ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SLT: calc.result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NOR: calc.result = ~(op_a | op_b);
            default: calc.illegal = 1'b1;
        endcase
        calc.zero = (calc.result == '0);
    end

    // ---------------- output stage ----------------
    res_t out_q;
    logic out_valid_q;
    logic in_ready_w;
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.in_valid & in_ready_w;
    assign out_xfer = out_valid_q & bus.out_ready;

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = out_q.result;
    assign bus.zero       = out_q.zero;
    assign bus.ovf        = out_q.ovf;
    assign bus.illegal_op = out_q.illegal;

`ifdef ALU_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    res_t   skid_q;
    logic   in_ready_q;

    assign in_ready_w = in_ready_q;
    assign dbg_state  = state;

    // in_ready_q mirrors (next state != FULL) so upstream never sees a
    // combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_q       <= calc;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        // Output is stalled: park the new result behind it.
                        skid_q     <= calc;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (!in_xfer && out_xfer) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        out_q <= calc;
                    end
                end
                FULL: begin
                    // in_ready is 0 here, so only a drain can happen.
                    if (out_xfer) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= EMPTY;
                end
            endcase
        end
    end
`else
    assign in_ready_w = ~out_valid_q | bus.out_ready;
    assign dbg_state  = {1'b0, out_valid_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (in_xfer) begin
            // Covers simultaneous in/out: new result replaces the old one.
            out_q       <= calc;
            out_valid_q <= 1'b1;
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

endmodule
